// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data memory with B/H/W access, multi-cycle
// loads, fault detection and a sequential clear that runs after reset.
// Parameters: DEPTH (32-bit words, power of two), LAT (load cycles >= 1).
// Ports: clk, reset (sync, active-high), MemRead, MemWrite, funct3,
//   Address, Write_data -> Read_Data, RValid, Stall, Err.
// Optional: define DMEM_BOUNDS_CHECK_EN to fault on nonzero upper
//   address bits instead of letting them alias into the array.
module data_mem_ctrl #(
  parameter int DEPTH = 64,
  parameter int LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_Data,
  output logic        RValid,
  output logic        Stall,
  output logic        Err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (LAT >= 2) ? CW'(LAT - 2) : '0;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] clr_q, clr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [AW-1:0] in_idx;
  logic          is_idle;
  logic          both;
  logic          ld_bad;
  logic          st_bad;
  logic          mis;
  logic          oob;
  logic          fault;
  logic          ld_ok;
  logic          st_ok;

  assign in_idx  = Address[AW+1:2];
  assign is_idle = (state_q == S_IDLE);

  // Fault classification
  assign both   = MemRead & MemWrite;
  assign ld_bad = MemRead &
                  ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));
  assign st_bad = MemWrite &
                  (funct3[2] | (funct3[1:0] == 2'b11));
  // Halfword needs even address, word needs 4-byte alignment.
  assign mis = ((funct3[1:0] == 2'b01) & Address[0]) |
               ((funct3[1:0] == 2'b10) & (|Address[1:0]));

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = |Address[31:AW+2];
`else
  logic unused_hi;
  assign unused_hi = ^Address[31:AW+2];
  assign oob = 1'b0;
`endif

  assign fault = is_idle & (MemRead | MemWrite) &
                 (both | ld_bad | st_bad | mis | oob);
  assign ld_ok = is_idle & MemRead & ~fault;
  assign st_ok = is_idle & MemWrite & ~fault;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLEAR: begin
        if (clr_q == LAST_IDX) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (ld_ok) state_d = (LAT == 1) ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Outputs
  always_comb begin
    Stall  = (state_q == S_CLEAR) |
             (state_q == S_BUSY)  |
             (is_idle & MemRead & ~fault);
    RValid = (state_q == S_DONE);
  end

  assign Read_Data = rdata_q;
  assign Err       = err_q;

  // Load result formatting
  function automatic logic [31:0] fmt(
    input logic [31:0] w,
    input logic [1:0]  ln,
    input logic [2:0]  f
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (ln)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ln[1] ? w[31:16] : w[15:0];
    unique case (f)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // With LAT == 1 the result is formatted from the live request at
  // the acceptance edge; otherwise from the latched request.
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [2:0]    r_f3;

  always_comb begin
    if (is_idle) begin
      r_idx  = in_idx;
      r_lane = Address[1:0];
      r_f3   = funct3;
    end else begin
      r_idx  = idx_q;
      r_lane = lane_q;
      r_f3   = f3_q;
    end
  end

  // Datapath next-state
  always_comb begin
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = fault;
    if (state_q == S_CLEAR) clr_d = clr_q + 1'b1;
    if (ld_ok) begin
      cnt_d  = CNT_INIT;
      idx_d  = in_idx;
      lane_d = Address[1:0];
      f3_d   = funct3;
    end
    if (state_q == S_BUSY && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    if (state_d == S_DONE) rdata_d = fmt(mem_q[r_idx], r_lane, r_f3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store lane enables and replicated data
  logic [3:0]  be;
  logic [31:0] wdat;

  always_comb begin
    be   = 4'b1111;
    wdat = Write_data;
    unique case (funct3[1:0])
      2'b00: begin
        be   = 4'b0001 << Address[1:0];
        wdat = {4{Write_data[7:0]}};
      end
      2'b01: begin
        be   = Address[1] ? 4'b1100 : 4'b0011;
        wdat = {2{Write_data[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = Write_data;
      end
    endcase
  end

  // Array: no reset of contents; the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        mem_q[clr_q] <= '0;
      end else if (st_ok) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem_q[in_idx][8*i +: 8] <= wdat[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl (DEPTH=64, LAT=3).
// Covers clear, B/H/W stores and loads, latency, faults, reset abort.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_Data;
  logic        RValid;
  logic        Stall;
  logic        Err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .DEPTH(64),
    .LAT  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .Address   (Address),
    .Write_data(Write_data),
    .Read_Data (Read_Data),
    .RValid    (RValid),
    .Stall     (Stall),
    .Err       (Err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    funct3     = 3'b000;
    Address    = 32'd0;
    Write_data = 32'd0;
  endtask

  // Entered just after the reset edge; counts stalled cycles.
  task automatic count_clear(input string tag);
    int   n;
    logic rv;
    n  = 0;
    rv = 1'b0;
    @(negedge clk);
    while (Stall && n < 200) begin
      n++;
      if (RValid) rv = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_stall"}, n, 64);
    chk({tag, "_rv"}, {31'd0, rv}, 32'd0);
    tick();
  endtask

  task automatic do_store(input string tag,
                          input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [31:0] d);
    MemWrite   = 1'b1;
    funct3     = f3;
    Address    = a;
    Write_data = d;
    @(negedge clk);
    chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
    tick();
    idle_in();
    @(negedge clk);
    chk({tag, "_err"}, {31'd0, Err}, 32'd0);
    tick();
  endtask

  task automatic do_load(input string tag,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] exp);
    int s;
    s       = 0;
    MemRead = 1'b1;
    funct3  = f3;
    Address = a;
    @(negedge clk);
    while (Stall && s < 20) begin
      s++;
      @(negedge clk);
    end
    chk({tag, "_stalls"}, s, 3);
    chk({tag, "_rv"}, {31'd0, RValid}, 32'd1);
    chk({tag, "_data"}, Read_Data, exp);
    tick();
    idle_in();
    @(negedge clk);
    chk({tag, "_rv_off"}, {31'd0, RValid}, 32'd0);
    chk({tag, "_no_rerun"}, {31'd0, Stall}, 32'd0);
    tick();
  endtask

  task automatic do_fault(input string tag,
                          input logic rd,
                          input logic wr,
                          input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [31:0] exp_rd);
    MemRead    = rd;
    MemWrite   = wr;
    funct3     = f3;
    Address    = a;
    Write_data = d;
    @(negedge clk);
    chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
    tick();
    idle_in();
    @(negedge clk);
    chk({tag, "_err"}, {31'd0, Err}, 32'd1);
    chk({tag, "_rd_hold"}, Read_Data, exp_rd);
    tick();
    @(negedge clk);
    chk({tag, "_err_off"}, {31'd0, Err}, 32'd0);
    tick();
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    tick();
    chk("rst_rdata", Read_Data, 32'd0);
    chk("rst_rvalid", {31'd0, RValid}, 32'd0);
    chk("rst_err", {31'd0, Err}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd1);
    reset = 1'b0;
    count_clear("clear");

    do_load("lw_fc", 3'b010, 32'h0FC, 32'h0000_0000);

    do_store("sw_10", 3'b010, 32'h10, 32'h1122_3344);
    do_store("sb_11", 3'b000, 32'h11, 32'h0000_00AA);
    do_store("sh_12", 3'b001, 32'h12, 32'h0000_8001);
    do_load("lw_10", 3'b010, 32'h10, 32'h8001_AA44);
    do_load("lb_11", 3'b000, 32'h11, 32'hFFFF_FFAA);
    do_load("lbu_11", 3'b100, 32'h11, 32'h0000_00AA);
    do_load("lh_12", 3'b001, 32'h12, 32'hFFFF_8001);
    do_load("lhu_12", 3'b101, 32'h12, 32'h0000_8001);

    do_store("sw_20", 3'b010, 32'h20, 32'hDEAD_BEEF);
    do_load("lw_20", 3'b010, 32'h20, 32'hDEAD_BEEF);

    do_fault("f_lw_mis", 1'b1, 1'b0, 3'b010, 32'h22, 32'h0,
             32'hDEAD_BEEF);
    do_fault("f_sh_mis", 1'b0, 1'b1, 3'b001, 32'h23, 32'hFFFF,
             32'hDEAD_BEEF);
    do_fault("f_both", 1'b1, 1'b1, 3'b010, 32'h20, 32'h0,
             32'hDEAD_BEEF);
    do_fault("f_ld011", 1'b1, 1'b0, 3'b011, 32'h20, 32'h0,
             32'hDEAD_BEEF);
    do_fault("f_st100", 1'b0, 1'b1, 3'b100, 32'h20, 32'h55,
             32'hDEAD_BEEF);
    do_load("lw_20_kept", 3'b010, 32'h20, 32'hDEAD_BEEF);

`ifdef DMEM_BOUNDS_CHECK_EN
    do_fault("f_oob", 1'b0, 1'b1, 3'b010, 32'h100, 32'h1234_5678,
             32'hDEAD_BEEF);
    do_load("lw_0_oob", 3'b010, 32'h0, 32'h0000_0000);
`else
    do_store("sw_alias", 3'b010, 32'h100, 32'h1234_5678);
    do_load("lw_0_alias", 3'b010, 32'h0, 32'h1234_5678);
`endif

    // Reset while a load is in BUSY, with a store on the bus.
    MemRead = 1'b1;
    funct3  = 3'b010;
    Address = 32'h10;
    tick();
    reset      = 1'b1;
    MemRead    = 1'b0;
    MemWrite   = 1'b1;
    funct3     = 3'b010;
    Address    = 32'h14;
    Write_data = 32'hCAFE_F00D;
    tick();
    reset = 1'b0;
    idle_in();
    chk("mid_rst_rdata", Read_Data, 32'd0);
    chk("mid_rst_rv", {31'd0, RValid}, 32'd0);
    count_clear("reclear");
    do_load("lw_10_clr", 3'b010, 32'h10, 32'h0000_0000);
    do_load("lw_14_clr", 3'b010, 32'h14, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data memory for the MEM stage of the 5-stage RISC-V core.
- Supports byte, halfword and word loads/stores (RV32I funct3) with sign/zero extension.
- Reads take a configurable multi-cycle latency and stall the pipeline while pending.
- Detects misaligned or illegal accesses.
- Clears its array sequentially after reset, one word per cycle, while holding the pipeline stalled.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, >= 2; index bits AW = log2(DEPTH).
LAT, 1, read latency in cycles; >= 1; number of cycles Stall is held for a load.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
MemRead  input  1  load request.
MemWrite  input  1  store request.
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
Address  input  32  byte address.
Write_data  input  32  store data; low byte/half used for SB/SH.
Read_Data  output  32  formatted load result; registered; held until the next load completes.
RValid  output  1  one-cycle pulse; Read_Data valid for the current load.
Stall  output  1  freeze PC/IF/ID/EX/MEM registers.
Err  output  1  one-cycle registered pulse; the access was dropped.

Behaviour:
- Word index = Address[AW+1:2]; byte lane = Address[1:0]; Address[31:AW+2] ignored (aliases) unless the optional feature is on.
- States: CLEAR, IDLE, BUSY, DONE.
- Reset (sampled at an edge):
  - state <= CLEAR, clear index <= 0.
  - Read_Data <= 0, RValid <= 0, Err <= 0; latency counter <= 0.
  - Any access in flight is aborted; a store presented in the reset cycle is not written.
- CLEAR:
  - Each cycle write 0 to word[clear index], then increment.
  - After word DEPTH-1 is written, go to IDLE (DEPTH cycles total).
  - Stall = 1 throughout; requests ignored.
- Fault (IDLE only), if any of these hold:
  - MemRead & MemWrite both high.
  - funct3 illegal: loads 011/110/111; stores any value other than 000/001/010.
  - Halfword access with Address[0] = 1.
  - Word access with Address[1:0] != 0.
- Fault response: no array access, no state change, Stall = 0, Err = 1 in the following cycle.
- IDLE store (MemWrite, no fault):
  - Byte lanes written at this edge with no stall.
  - SB writes lane Address[1:0]; SH writes lanes {Address[1],0} and {Address[1],1}; SW writes all lanes.
  - Unselected lanes are preserved.
  - Back-to-back stores proceed at 1 per cycle.
- IDLE load (MemRead, no fault):
  - Stall = 1 combinationally in the request cycle.
  - Address and funct3 are latched at the edge.
  - If LAT = 1, go to DONE; otherwise go to BUSY with counter = LAT-2.
- BUSY: Stall = 1; requests ignored (this is the held load). Decrement the counter; at 0, go to DONE.
- DONE:
  - RValid = 1, Stall = 0; Read_Data is updated at the entering edge.
  - The held request is ignored; return to IDLE.
  - A new request is accepted only in the following IDLE cycle.
- Load formatting, from the latched word and lane:
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend half Address[1]. LHU: zero-extend it.
  - LW: word unchanged.
- Stall = (state==CLEAR) | (state==BUSY) | (state==IDLE & MemRead & !fault).
- Net timing: a load holds Stall for exactly LAT cycles; RValid asserts in the cycle after the last stalled cycle.
- Read data reflects array contents at the acceptance edge. A store cannot occur during a pending load, so there is no hazard.

Optional Feature:
DMEM_BOUNDS_CHECK_EN
- Defined: Address[31:AW+2] != 0 is an additional fault condition. Access dropped, Err pulse, no stall, no write.
- Undefined: upper address bits are ignored and out-of-range addresses alias into the array.

Test Plan:
- Reset clear (DEPTH=64, LAT=2): assert reset 1 cycle -> Stall high exactly 64 cycles; then LW 0x0FC -> Read_Data = 0x00000000, RValid pulse.
- Byte/half stores (LAT=1):
  - Sequence: SW 0x10 = 0x11223344, then SB 0x11 = 0xAA, then SH 0x12 = 0x8001.
  - Expected: LW 0x10 -> 0x8001AA44; LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
- Latency (LAT=3): LW 0x20 holding 0xDEADBEEF -> Stall high 3 cycles; RValid and Read_Data = 0xDEADBEEF in the 4th cycle; no second read triggered by the held request.
- Faults:
  - LW 0x22 -> Err pulse next cycle, Stall 0, Read_Data unchanged.
  - SH 0x23 = 0xFFFF -> Err pulse, word 0x20 unchanged.
  - MemRead & MemWrite together -> Err pulse.
  - funct3 = 011 load -> Err pulse.
- Reset mid-operation: reset asserted during BUSY of LW (LAT=4) -> no RValid, state CLEAR, full 64-cycle clear re-runs; SW presented in the reset cycle is not written.
- Bounds (DMEM_BOUNDS_CHECK_EN): SW 0x100 = 0x12345678 -> Err pulse, word 0 still 0. Without the macro, the same SW writes word 0; LW 0x0 returns 0x12345678.
